// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_pkg
// Description : Shared widths, default latencies and stage indices for the
//               D-stage hazard scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_scoreboard_pkg;

  // Default field widths
  localparam int T_W_DEF  = 2;
  localparam int RA_W_DEF = 5;

  // A Tuse of all ones marks an operand the instruction never reads
  localparam logic [T_W_DEF-1:0] TUSE_NONE = '1;

  // Default multiply/divide occupancy in cycles
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Stage indices; STG_RF doubles as the "read register file" forward select
  localparam int STG_RF = 0;
  localparam int STG_E  = 1;
  localparam int STG_M  = 2;
  localparam int STG_W  = 3;

endpackage
`default_nettype wire

// File: rtl/md_busy_counter.sv
`default_nettype none
// ============================================================================
// Module      : md_busy_counter
// Description : Occupancy counter for the multi-cycle mult/div unit. Loads the
//               operation latency one cycle after the op enters E and counts
//               down to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module md_busy_counter
  import hazard_scoreboard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic e_md,
  input  logic e_div,
  output logic md_busy
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] count;

  // Load the latency when an md op sits in E, otherwise count down to zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (e_md) begin
      count <= e_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  // The op in E already occupies the unit before the counter is loaded
  assign md_busy = (count != '0) | e_md;

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Stateful D-stage hazard unit. Tracks in-flight producers with
//               self-decrementing Tnew, resolves stall and per-operand
//               forwarding selects, and interlocks HI/LO users on the md unit.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int T_W         = T_W_DEF,
  parameter int RA_W        = RA_W_DEF,
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int SEL_W       = $clog2(NUM_STAGES + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             d_valid,
  input  logic [RA_W-1:0]  d_rs,
  input  logic [RA_W-1:0]  d_rt,
  input  logic [T_W-1:0]   d_tuse1,
  input  logic [T_W-1:0]   d_tuse2,
  input  logic [RA_W-1:0]  d_dst,
  input  logic [T_W-1:0]   d_tnew,
  input  logic             d_md_start,
  input  logic             d_md_div,
  input  logic             d_hilo_use,
  output logic             stall,
  output logic [SEL_W-1:0] fwd_rs_sel,
  output logic [SEL_W-1:0] fwd_rt_sel,
  output logic             md_busy
);

  localparam logic [T_W-1:0] TUSE_OFF = '1;

  // Producer table, index 1 = E ... NUM_STAGES = oldest tracked stage
  logic [NUM_STAGES:1] v;
  logic [RA_W-1:0]     dst  [1:NUM_STAGES];
  logic [T_W-1:0]      tnew [1:NUM_STAGES];

  logic [NUM_STAGES:1] hit_rs, hit_rt;
  logic                rs_found, rt_found;
  logic [SEL_W-1:0]    rs_k, rt_k;
  logic [T_W-1:0]      rs_t, rt_t;
  logic                rs_active, rt_active;
  logic                rs_hazard, rt_hazard, md_hazard;
  logic                issue;
  logic                e_md, e_div;

  function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] t);
    return (t == '0) ? '0 : t - T_W'(1);
  endfunction

  // Per-stage address compare for both operands
  for (genvar k = 1; k <= NUM_STAGES; k++) begin : g_match
    assign hit_rs[k] = v[k] && (dst[k] == d_rs);
    assign hit_rt[k] = v[k] && (dst[k] == d_rt);
  end

  // Priority pick: scanning oldest to youngest leaves the youngest producer
  always_comb begin
    rs_found = 1'b0;
    rs_k     = SEL_W'(STG_RF);
    rs_t     = '0;
    rt_found = 1'b0;
    rt_k     = SEL_W'(STG_RF);
    rt_t     = '0;
    for (int k = NUM_STAGES; k >= 1; k--) begin
      if (hit_rs[k]) begin
        rs_found = 1'b1;
        rs_k     = SEL_W'(k);
        rs_t     = tnew[k];
      end
      if (hit_rt[k]) begin
        rt_found = 1'b1;
        rt_k     = SEL_W'(k);
        rt_t     = tnew[k];
      end
    end
  end

  // $0 and unused operands never create a dependency
  assign rs_active = (d_rs != '0) && (d_tuse1 != TUSE_OFF) && rs_found;
  assign rt_active = (d_rt != '0) && (d_tuse2 != TUSE_OFF) && rt_found;

  assign rs_hazard = rs_active && (rs_t > d_tuse1);
  assign rt_hazard = rt_active && (rt_t > d_tuse2);
  assign md_hazard = d_hilo_use && md_busy;

  assign stall = d_valid && (rs_hazard || rt_hazard || md_hazard);

  // Forward only once the producer has its result; otherwise read the RF
  assign fwd_rs_sel = (rs_active && (rs_t == '0)) ? rs_k : SEL_W'(STG_RF);
  assign fwd_rt_sel = (rt_active && (rt_t == '0)) ? rt_k : SEL_W'(STG_RF);

  assign issue = d_valid && !stall && (d_dst != '0);

  // Shift the table every cycle; a stalled or empty D slot enters E as a bubble
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 1; k <= NUM_STAGES; k++) begin
        v[k]    <= 1'b0;
        dst[k]  <= '0;
        tnew[k] <= '0;
      end
    end else begin
      v[STG_E]    <= issue;
      dst[STG_E]  <= issue ? d_dst : '0;
      tnew[STG_E] <= issue ? d_tnew : '0;
      for (int k = 1; k < NUM_STAGES; k++) begin
        v[k+1]    <= v[k];
        dst[k+1]  <= dst[k];
        tnew[k+1] <= sat_dec(tnew[k]);
      end
    end
  end

  // Track an md op entering E together with its divide flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_md  <= 1'b0;
      e_div <= 1'b0;
    end else begin
      e_md  <= d_md_start && d_valid && !stall;
      e_div <= d_md_div;
    end
  end

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .e_md    (e_md),
    .e_div   (e_div),
    .md_busy (md_busy)
  );

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Self-checking bench for hazard_scoreboard. Each D-stage vector
//               carries its expected outputs, queued on drive and compared
//               mid-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam logic [1:0] N = TUSE_NONE;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       d_valid, d_md_start, d_md_div, d_hilo_use;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_tuse1, d_tuse2, d_tnew;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs, rt;
    logic [1:0] tu1, tu2;
    logic [4:0] dst;
    logic [1:0] tnew;
    logic       mds, mdd, hilo;
    logic       e_stall;
    logic [1:0] e_rs, e_rt;
    logic       e_busy;
  } step_t;

  typedef struct packed {
    logic       stall;
    logic [1:0] rs, rt;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  hazard_scoreboard dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .d_valid    (d_valid),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse1    (d_tuse1),
    .d_tuse2    (d_tuse2),
    .d_dst      (d_dst),
    .d_tnew     (d_tnew),
    .d_md_start (d_md_start),
    .d_md_div   (d_md_div),
    .d_hilo_use (d_hilo_use),
    .stall      (stall),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel),
    .md_busy    (md_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic step_t mk(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [1:0] tu1, input logic [1:0] tu2,
                               input logic [4:0] dst, input logic [1:0] tnew,
                               input logic mds, input logic mdd, input logic hilo,
                               input logic es, input logic [1:0] ers,
                               input logic [1:0] ert, input logic eb);
    step_t s;
    s = '{valid, rs, rt, tu1, tu2, dst, tnew, mds, mdd, hilo, es, ers, ert, eb};
    return s;
  endfunction

  task automatic set_inputs(input step_t s);
    d_valid    = s.valid;
    d_rs       = s.rs;
    d_rt       = s.rt;
    d_tuse1    = s.tu1;
    d_tuse2    = s.tu2;
    d_dst      = s.dst;
    d_tnew     = s.tnew;
    d_md_start = s.mds;
    d_md_div   = s.mdd;
    d_hilo_use = s.hilo;
  endtask

  task automatic drive(input step_t s);
    set_inputs(s);
    sb.push_back('{s.e_stall, s.e_rs, s.e_rt, s.e_busy});
  endtask

  task automatic flush(input int n);
    set_inputs(mk(0, 0, 0, N, N, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t seq[$];
    exp_t  e;
    seq.push_back(mk(1, 8, 9, 0, 0, 4, 2, 1, 1, 1, 0, 0, 0, 0));
    seq.push_back(mk(1, 4, 9, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if ({stall, fwd_rs_sel, fwd_rt_sel, md_busy} !== e) begin
        miscompares++;
        $display("FAIL reset step %0d: got stall=%b rs=%0d rt=%0d busy=%b want stall=%b rs=%0d rt=%0d busy=%b",
                 i, stall, fwd_rs_sel, fwd_rt_sel, md_busy, e.stall, e.rs, e.rt, e.busy);
      end
      @(posedge clk);
      #1;
    end
    reset_n = 1'b1;
    flush(2);
  endtask

  task automatic test_load_use();
    step_t seq[$];
    exp_t  e;
    seq.push_back(mk(1, 29, 0, 1, N, 8, 2, 0, 0, 0, 0, 0, 0, 0)); // lw $8
    seq.push_back(mk(1, 8, 1, 1, 1, 9, 1, 0, 0, 0, 1, 0, 0, 0));  // addu stalls
    seq.push_back(mk(1, 8, 1, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0));  // tnew 1 <= tuse 1
    seq.push_back(mk(0, 8, 0, 0, N, 0, 0, 0, 0, 0, 0, 3, 0, 0));  // lw now in W, tnew 0
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if ({stall, fwd_rs_sel, fwd_rt_sel, md_busy} !== e) begin
        miscompares++;
        $display("FAIL load_use step %0d: got stall=%b rs=%0d rt=%0d busy=%b want stall=%b rs=%0d rt=%0d busy=%b",
                 i, stall, fwd_rs_sel, fwd_rt_sel, md_busy, e.stall, e.rs, e.rt, e.busy);
      end
      @(posedge clk);
      #1;
    end
    flush(4);
  endtask

  task automatic test_branch();
    step_t seq[$];
    exp_t  e;
    seq.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0)); // addu $3
    seq.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); // beq stalls
    seq.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0)); // forward from M
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if ({stall, fwd_rs_sel, fwd_rt_sel, md_busy} !== e) begin
        miscompares++;
        $display("FAIL branch step %0d: got stall=%b rs=%0d rt=%0d busy=%b want stall=%b rs=%0d rt=%0d busy=%b",
                 i, stall, fwd_rs_sel, fwd_rt_sel, md_busy, e.stall, e.rs, e.rt, e.busy);
      end
      @(posedge clk);
      #1;
    end
    flush(4);
  endtask

  task automatic test_youngest();
    step_t seq[$];
    exp_t  e;
    seq.push_back(mk(1, 0, 0, N, N, 5, 0, 0, 0, 0, 0, 0, 0, 0)); // ori $5
    seq.push_back(mk(1, 0, 0, N, N, 5, 0, 0, 0, 0, 0, 0, 0, 0)); // ori $5 again
    seq.push_back(mk(1, 5, 5, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0)); // E wins over M
    seq.push_back(mk(0, 5, 5, 1, 1, 0, 0, 0, 0, 0, 0, 2, 2, 0)); // M wins over W
    seq.push_back(mk(0, 5, 5, 1, 1, 0, 0, 0, 0, 0, 0, 3, 3, 0)); // only W left
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if ({stall, fwd_rs_sel, fwd_rt_sel, md_busy} !== e) begin
        miscompares++;
        $display("FAIL youngest step %0d: got stall=%b rs=%0d rt=%0d busy=%b want stall=%b rs=%0d rt=%0d busy=%b",
                 i, stall, fwd_rs_sel, fwd_rt_sel, md_busy, e.stall, e.rs, e.rt, e.busy);
      end
      @(posedge clk);
      #1;
    end
    flush(4);
  endtask

  task automatic test_rt_hazard();
    step_t seq[$];
    exp_t  e;
    seq.push_back(mk(1, 29, 0, 1, N, 7, 2, 0, 0, 0, 0, 0, 0, 0)); // lw $7
    seq.push_back(mk(1, 0, 7, N, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));  // tnew 2 > 0
    seq.push_back(mk(1, 0, 7, N, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));  // tnew 1 > 0
    seq.push_back(mk(1, 0, 7, N, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0));  // forward from W
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if ({stall, fwd_rs_sel, fwd_rt_sel, md_busy} !== e) begin
        miscompares++;
        $display("FAIL rt_hazard step %0d: got stall=%b rs=%0d rt=%0d busy=%b want stall=%b rs=%0d rt=%0d busy=%b",
                 i, stall, fwd_rs_sel, fwd_rt_sel, md_busy, e.stall, e.rs, e.rt, e.busy);
      end
      @(posedge clk);
      #1;
    end
    flush(4);
  endtask

  task automatic test_zero_unused();
    step_t seq[$];
    exp_t  e;
    seq.push_back(mk(1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0)); // write to $0
    seq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // read $0
    seq.push_back(mk(1, 0, 0, N, N, 6, 0, 0, 0, 0, 0, 0, 0, 0)); // ori $6
    seq.push_back(mk(1, 6, 6, N, N, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // unused operands
    seq.push_back(mk(1, 6, 0, 0, N, 0, 0, 0, 0, 0, 0, 2, 0, 0)); // used, from M
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if ({stall, fwd_rs_sel, fwd_rt_sel, md_busy} !== e) begin
        miscompares++;
        $display("FAIL zero_unused step %0d: got stall=%b rs=%0d rt=%0d busy=%b want stall=%b rs=%0d rt=%0d busy=%b",
                 i, stall, fwd_rs_sel, fwd_rt_sel, md_busy, e.stall, e.rs, e.rt, e.busy);
      end
      @(posedge clk);
      #1;
    end
    flush(4);
  endtask

  task automatic test_md();
    step_t seq[$];
    exp_t  e;
    seq.push_back(mk(1, 4, 5, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0));  // div
    for (int j = 0; j < 1 + DIV_CYCLES_DEF; j++)
      seq.push_back(mk(1, 0, 0, N, N, 2, 1, 0, 0, 1, 1, 0, 0, 1)); // mflo held
    seq.push_back(mk(1, 0, 0, N, N, 2, 1, 0, 0, 1, 0, 0, 0, 0));  // mflo issues
    seq.push_back(mk(1, 4, 5, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0));  // mult
    for (int j = 0; j < 1 + MULT_CYCLES_DEF; j++)
      seq.push_back(mk(1, 0, 0, N, N, 2, 1, 0, 0, 1, 1, 0, 0, 1));
    seq.push_back(mk(1, 0, 0, N, N, 2, 1, 0, 0, 1, 0, 0, 0, 0));
    seq.push_back(mk(1, 4, 5, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0));  // mult
    seq.push_back(mk(1, 0, 0, N, N, 9, 1, 0, 0, 0, 0, 0, 0, 1));  // non-HI/LO op passes
    seq.push_back(mk(1, 0, 0, N, N, 2, 1, 0, 0, 1, 1, 0, 0, 1));  // mflo still held
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if ({stall, fwd_rs_sel, fwd_rt_sel, md_busy} !== e) begin
        miscompares++;
        $display("FAIL md step %0d: got stall=%b rs=%0d rt=%0d busy=%b want stall=%b rs=%0d rt=%0d busy=%b",
                 i, stall, fwd_rs_sel, fwd_rt_sel, md_busy, e.stall, e.rs, e.rt, e.busy);
      end
      @(posedge clk);
      #1;
    end
    flush(12);
  endtask

  task automatic test_reset_mid();
    step_t seq[$];
    exp_t  e;
    step_t addu;
    addu = mk(1, 8, 6, 1, 1, 9, 1, 0, 0, 1, 1, 0, 2, 1);
    seq.push_back(mk(1, 4, 5, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0));   // div
    seq.push_back(mk(1, 0, 0, N, N, 6, 0, 0, 0, 0, 0, 0, 0, 1));   // ori $6
    seq.push_back(mk(1, 29, 0, 1, N, 8, 2, 0, 0, 0, 0, 0, 0, 1));  // lw $8
    seq.push_back(addu);                                            // stalled, rt from M
    seq.push_back(addu);                                            // async reset mid-cycle
    seq.push_back(mk(1, 8, 6, 1, 1, 9, 1, 0, 0, 1, 0, 0, 0, 0));   // after release
    seq.push_back(mk(1, 9, 0, 0, N, 0, 0, 0, 0, 0, 1, 0, 0, 0));   // addu did issue
    foreach (seq[i]) begin
      if (i == 4) begin
        #2 reset_n = 1'b0;
        sb.push_back('{1'b0, 2'd0, 2'd0, 1'b0});
        #1;
      end else begin
        if (i == 5) reset_n = 1'b1;
        drive(seq[i]);
        @(negedge clk);
      end
      e = sb.pop_front();
      vectors++;
      if ({stall, fwd_rs_sel, fwd_rt_sel, md_busy} !== e) begin
        miscompares++;
        $display("FAIL reset_mid step %0d: got stall=%b rs=%0d rt=%0d busy=%b want stall=%b rs=%0d rt=%0d busy=%b",
                 i, stall, fwd_rs_sel, fwd_rt_sel, md_busy, e.stall, e.rs, e.rt, e.busy);
      end
      if (i != 3) begin
        @(posedge clk);
        #1;
      end
    end
    flush(4);
  endtask

  initial begin
    set_inputs(mk(0, 0, 0, N, N, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_youngest();
    test_rt_hazard();
    test_zero_unused();
    test_md();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised, stateful hazard unit for the pipelined MIPS core; successor to the per-instruction Tuse/Tnew decode.
- Sits beside the D stage and consumes the decoded {rs, rt, Tuse1, Tuse2, dst, Tnew} of the D-stage instruction.
- Tracks in-flight producers through NUM_STAGES downstream stages with self-decrementing Tnew.
- Models a multi-cycle mult/div unit with a busy counter, and emits stall plus per-operand forwarding selects.

Parameters:
- NUM_STAGES, 3, downstream stages tracked (1=E, 2=M, 3=W).
- T_W, 2, width of Tuse/Tnew fields; Tuse all-ones (3) = operand unused.
- RA_W, 5, register address width.
- MULT_CYCLES, 5, busy cycles for mult/multu/madd.
- DIV_CYCLES, 10, busy cycles for div/divu.
- SEL_W, $clog2(NUM_STAGES+1), forwarding select width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- d_valid  in  1  D-stage holds a real instruction.
- d_rs  in  RA_W  source 1 address.
- d_rt  in  RA_W  source 2 address.
- d_tuse1  in  T_W  Tuse for rs.
- d_tuse2  in  T_W  Tuse for rt.
- d_dst  in  RA_W  destination register (0 = none).
- d_tnew  in  T_W  Tnew measured at E entry.
- d_md_start  in  1  instruction starts mult/div/madd.
- d_md_div  in  1  qualifies d_md_start as divide.
- d_hilo_use  in  1  instruction touches HI/LO (md, mfhi/lo, mthi/lo, madd).
- stall  out  1  freeze PC/F/D, insert bubble into E.
- fwd_rs_sel  out  SEL_W  0 = register file, k = forward from stage k.
- fwd_rt_sel  out  SEL_W  as above for rt.
- md_busy  out  1  mult/div unit occupied.

Behaviour:
- Table: per stage k, registers {v[k], dst[k], tnew[k]}.
- Reset (async, reset_n=0): all v=0, dst=0, tnew=0, md counter=0, e_md=0. Outputs then read stall=0, fwd_*_sel=0, md_busy=0.
- Reset mid-operation discards all in-flight entries and any running md count immediately.
- Advance, every cycle:
  - entry[k+1] <= entry[k] with tnew = sat_dec(tnew), where sat_dec(0)=0.
  - entry[NUM_STAGES] drops out.
  - The table never freezes.
- Issue into stage 1:
  - If d_valid & ~stall & d_dst!=0: {1, d_dst, d_tnew}.
  - Otherwise a bubble {0, 0, 0}; a stall therefore always bubbles E.
- Match, combinational, per operand addr a with tuse u:
  - Skip if a==0 or u==all-ones.
  - k* = smallest k with v[k] & dst[k]==a (the youngest producer wins).
  - If no match, sel=0.
- Data hazard: stall if a match exists and tnew[k*] > u.
- Forward select:
  - fwd_sel = k* if a match exists and tnew[k*]==0, else 0.
  - When tnew[k*] != 0 but <= u, sel=0 this cycle; the consumer re-evaluates in later stages (not this block's job).
- MD unit:
  - e_md registers (d_md_start & d_valid & ~stall).
  - When e_md=1, the counter loads MULT_CYCLES or DIV_CYCLES (registered div flag) in the next cycle.
  - Otherwise the counter decrements, saturating at 0.
  - md_busy = (counter!=0) | e_md.
- MD hazard: stall additionally if d_valid & d_hilo_use & md_busy.
- Combined: stall = d_valid & (rs_hazard | rt_hazard | md_hazard).
- When d_valid=0: stall=0 and no issue.
- No combinational path from stall back into match logic except via issue gating.
- Latency: stall and fwd_sel are combinational from D inputs plus current table; table and counter update on the next edge.

Decomposition:
- Shared package/define file: T_W, RA_W, the TUSE_NONE constant, default MULT_CYCLES/DIV_CYCLES, and stage-index constants STG_RF=0, STG_E=1, STG_M=2, STG_W=3.
- One natural sub-module, md_busy_counter: e_md and div flag in, md_busy out; parametrised by both cycle counts.
- The match/priority logic stays as a generate loop in the top.

Test Plan:
- lw $8 (tnew=2) issued, next D addu $9,$8,$1 (tuse1=1): stall=1 for one cycle. Next cycle the lw is in M with tnew=1 <= 1, so stall=0 and fwd_rs_sel=0. The following cycle its W-stage entry has tnew=0, but the addu is already past D.
- addu $3 (tnew=1), then beq $3,$0 (tuse1=0): stall=1 for one cycle. Next cycle $3 is in M with tnew 0, so stall=0 and fwd_rs_sel=2.
- ori $5 then ori $5 again, then D reads $5 with tuse 1: fwd_rs_sel=1 (E holds the youngest producer, tnew 0 after lui-like/ori after one stage), not 2.
- Any write to $0 followed by a read of $0: stall=0, fwd sel 0.
- div issued, next D mflo: stall held for 1+DIV_CYCLES = 11 cycles and md_busy high throughout. After that, mflo issues. A mult then gives a 6-cycle hold.
- Drop reset_n low mid-div with pending lw in E: md_busy, stall and fwd outputs go 0 asynchronously. After release, a dependent addu issues with no stall.
